// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SLL  = 4'b0101, ALU_SRL  = 4'b0110, ALU_SRA  = 4'b0111,
        ALU_LTU  = 4'b1000, ALU_GEU  = 4'b1001, ALU_SLLI = 4'b1010, ALU_SRLI = 4'b1011,
        ALU_SRAI = 4'b1100, ALU_LT   = 4'b1101, ALU_GE   = 4'b1110
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER, S_EXECUTEI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    // Which funct-field table the ALU decoder should consult
    typedef enum logic [1:0] {ALU_CLS_ADD, ALU_CLS_R, ALU_CLS_I, ALU_CLS_BR} alu_cls_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return S_EXECUTER;
            OP_I:              return S_EXECUTEI;
            OP_BR:             return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/IR bundle: master is the control FSM, slave is the datapath.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU op select from the state's operation class and funct fields.
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_cls_t   cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_op_o
);
    logic imm;
    assign imm = (cls_i == ALU_CLS_I);

    always_comb begin
        alu_op_o = ALU_ADD;
        case (cls_i)
            ALU_CLS_R, ALU_CLS_I: begin
                case (funct3_i)
                    3'b000: if (!imm && funct7b5_i) alu_op_o = ALU_SUB;
                    3'b001: if (imm) alu_op_o = ALU_SLLI; else alu_op_o = ALU_SLL;
                    3'b010: alu_op_o = ALU_LT;
                    3'b011: alu_op_o = ALU_LTU;
                    3'b100: alu_op_o = ALU_XOR;
                    3'b101: begin
                        if (imm) alu_op_o = funct7b5_i ? ALU_SRAI : ALU_SRLI;
                        else     alu_op_o = funct7b5_i ? ALU_SRA  : ALU_SRL;
                    end
                    3'b110: alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
            ALU_CLS_BR: begin
                // Reserved branch funct3 values fall through to SUB and are never taken
                case (funct3_i)
                    3'b100:  alu_op_o = ALU_LT;
                    3'b101:  alu_op_o = ALU_GE;
                    3'b110:  alu_op_o = ALU_LTU;
                    3'b111:  alu_op_o = ALU_GEU;
                    default: alu_op_o = ALU_SUB;
                endcase
            end
            default: alu_op_o = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core with a single-signal memory wait.
// MULTICYCLE_ILLEGAL_TRAP_EN: ILLEGAL becomes a terminal trap and illegal_instr is sticky.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t     state_q, state_d;
    alu_cls_t   cls;
    logic [3:0] alu_op;
    logic       br_taken;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(bus.opcode);
            S_MEMADR:   if (bus.opcode == OP_LOAD) state_d = S_MEMREAD; else state_d = S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_JAL, S_JALR_LINK: state_d = S_ALUWB;
            S_JALR:     state_d = S_JALR_LINK;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        case (bus.funct3)
            3'b000:         br_taken = bus.zero;
            3'b010, 3'b011: br_taken = 1'b0;
            default:        br_taken = !bus.zero;
        endcase
    end

    // Reset forces every strobe and select low even though state already reads FETCH
    always_comb begin
        cls            = ALU_CLS_ADD;
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RD2;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.alu_src_b  = SRCB_4;
                    bus.result_src = RES_ALURES;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                S_DECODE, S_AUIPC: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMADR, S_JALR: begin
                    bus.alu_src_a = SRCA_RD1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMREAD:  bus.adr_src = 1'b1;
                S_MEMWB: begin
                    bus.result_src = RES_DATA;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.adr_src   = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    bus.alu_src_a = SRCA_RD1;
                    cls           = ALU_CLS_R;
                end
                S_EXECUTEI: begin
                    bus.alu_src_a = SRCA_RD1;
                    bus.alu_src_b = SRCB_IMM;
                    cls           = ALU_CLS_I;
                end
                S_LUI: begin
                    bus.alu_src_a = SRCA_ZERO;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_ALUWB:    bus.reg_write = 1'b1;
                S_BRANCH: begin
                    bus.alu_src_a = SRCA_RD1;
                    cls           = ALU_CLS_BR;
                    bus.pc_write  = br_taken;
                end
                S_JAL, S_JALR_LINK: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_4;
                    bus.pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    alu_decoder u_alu_dec (
        .cls_i      (cls),
        .funct3_i   (bus.funct3),
        .funct7b5_i (bus.funct7b5),
        .alu_op_o   (alu_op)
    );

    assign bus.alu_control = reset ? 4'b0000 : alu_op;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d = illegal_q | (state_q == S_DECODE && state_d == S_ILLEGAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
    assign bus.illegal_instr = illegal_q;
`else
    assign bus.illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: per-instruction expected output traces from a step-level model, checked every cycle.
module tb_multicycle_control;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if mif();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(mif));

    typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_e;
    typedef struct packed {
        logic pc, adr, mw, ir, rw;
        logic [1:0] res, sa, sb;
        logic [3:0] alu;
        logic ill;
    } ob_t;
    typedef struct {
        ob_t        e;
        bit         pin;
        logic [3:0] palu;
        logic       ppc;
        string      tag;
    } exp_t;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
        SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, LTU = 4'd8, GEU = 4'd9, SLLI = 4'd10,
        SRLI = 4'd11, SRAI = 4'd12, LT = 4'd13, GE = 4'd14;
    localparam logic [3:0] AOPS [8] = '{ADD, SLL, LT, LTU, XOR_, SRL, OR_, AND_};
    localparam logic [3:0] BOPS [8] = '{SUB, SUB, SUB, SUB, LT, GE, LTU, GEU};

    exp_t q[$];
    exp_t cx;
    ob_t  ca;
    int   total = 0;
    int   bad = 0;
    bit   ill_flag = 1'b0;

    function automatic logic [3:0] arith_op(bit imm, logic [2:0] f3, logic f7);
        logic [3:0] op;
        op = AOPS[f3];
        if (f3 == 3'd0 && f7 && !imm) op = SUB;
        if (f3 == 3'd1 && imm)        op = SLLI;
        if (f3 == 3'd5)               op = imm ? (f7 ? SRAI : SRLI) : (f7 ? SRA : SRL);
        return op;
    endfunction

    function automatic cls_e cls_of(logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int len_of(cls_e c);
        case (c)
            C_BR, C_ILL:  return 3;
            C_LD, C_JALR: return 5;
            default:      return 4;
        endcase
    endfunction

    // Expected outputs for cycle 'step' of an instruction (step 0 = fetch, 1 = decode)
    function automatic ob_t model(cls_e c, int step, logic [2:0] f3, logic f7, logic z, logic rdy, bit ill);
        ob_t o;
        bit  wb;
        o = '0;
        o.ill = ill;
        wb = (step == len_of(c) - 1) && (c inside {C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR});
        if (step == 0) begin
            o.ir = rdy; o.pc = rdy; o.sb = 2'b10; o.res = 2'b10;
        end else if (step == 1) begin
            o.sa = 2'b01; o.sb = 2'b01;
        end else if (wb) begin
            o.rw = 1'b1;
        end else begin
            case (c)
                C_R:     begin o.sa = 2'b10; o.alu = arith_op(1'b0, f3, f7); end
                C_I:     begin o.sa = 2'b10; o.sb = 2'b01; o.alu = arith_op(1'b1, f3, f7); end
                C_LUI:   begin o.sa = 2'b11; o.sb = 2'b01; end
                C_AUIPC: begin o.sa = 2'b01; o.sb = 2'b01; end
                C_LD, C_ST: begin
                    if (step == 2) begin o.sa = 2'b10; o.sb = 2'b01; end
                    else if (c == C_ST && step == 3) begin o.adr = 1'b1; o.mw = 1'b1; end
                    else if (step == 3) o.adr = 1'b1;
                    else begin o.res = 2'b01; o.rw = 1'b1; end
                end
                C_BR: begin
                    o.sa = 2'b10; o.alu = BOPS[f3];
                    o.pc = (f3 == 3'd0) ? z : ((f3 == 3'd2 || f3 == 3'd3) ? 1'b0 : !z);
                end
                C_JAL:   begin o.sa = 2'b01; o.sb = 2'b10; o.pc = 1'b1; end
                C_JALR: begin
                    if (step == 2) begin o.sa = 2'b10; o.sb = 2'b01; end
                    else begin o.sa = 2'b01; o.sb = 2'b10; o.pc = 1'b1; end
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    task automatic push(ob_t e, bit pin, logic [3:0] palu, logic ppc, string tag);
        exp_t x;
        x.e = e; x.pin = pin; x.palu = palu; x.ppc = ppc; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic do_reset(string tag, int n);
        reset = 1'b1;
        ill_flag = 1'b0;
        mif.mem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            push('0, 1'b0, 4'd0, 1'b0, tag);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // Called and returns at posedge+1; fw/mw are ready-low cycles in fetch and memory access
    task automatic run_instr(string tag, logic [6:0] opc, logic [2:0] f3, logic f7, logic z,
                             int fw, int mw, int pin_step, logic [3:0] palu, logic ppc,
                             int hold, int max_cyc);
        cls_e c;
        int   n, step, cyc, wf, wm;
        bit   waitable;
        logic rdy;
        c = cls_of(opc); n = len_of(c); step = 0; cyc = 0; wf = fw; wm = mw;
        while (step < n && cyc < max_cyc) begin
            waitable = (step == 0) || (step == 3 && (c == C_LD || c == C_ST));
            rdy = 1'b1;
            if (step == 0 && wf > 0) begin rdy = 1'b0; wf--; end
            else if (waitable && step == 3 && wm > 0) begin rdy = 1'b0; wm--; end
            if (TRAP && c == C_ILL && step == 2) ill_flag = 1'b1;
            mif.opcode = opc; mif.funct3 = f3; mif.funct7b5 = f7; mif.zero = z; mif.mem_ready = rdy;
            push(model(c, step, f3, f7, z, rdy, ill_flag), step == pin_step, palu, ppc, tag);
            if (!waitable || rdy) step++;
            cyc++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < hold; i++) begin
            mif.mem_ready = i[0];
            push(model(c, 2, f3, f7, z, 1'b1, ill_flag), 1'b0, 4'd0, 1'b0, tag);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cx = q.pop_front();
            ca = {mif.pc_write, mif.adr_src, mif.mem_write, mif.ir_write, mif.reg_write,
                  mif.result_src, mif.alu_src_a, mif.alu_src_b, mif.alu_control, mif.illegal_instr};
            total++;
            if (ca !== cx.e) begin
                bad++;
                $display("FAIL %s outputs: got=%h want=%h at %0t", cx.tag, ca, cx.e, $time);
            end
            if (cx.pin) begin
                total++;
                if (mif.alu_control !== cx.palu || mif.pc_write !== cx.ppc) begin
                    bad++;
                    $display("FAIL %s pin: got alu=%b pc=%b want alu=%b pc=%b",
                             cx.tag, mif.alu_control, mif.pc_write, cx.palu, cx.ppc);
                end
            end
        end
    end

    initial begin
        mif.opcode = '0; mif.funct3 = '0; mif.funct7b5 = 1'b0; mif.zero = 1'b0; mif.mem_ready = 1'b1;
        #6;
        do_reset("reset", 2);
        run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 2, 4'b0000, 1'b0, 0, 1000);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 2, 4'b0001, 1'b0, 0, 1000);
        run_instr("srai",  7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 2, 4'b1100, 1'b0, 0, 1000);
        run_instr("slli",  7'b0010011, 3'b001, 1'b0, 1'b0, 1, 0, 2, 4'b1010, 1'b0, 0, 1000);
        run_instr("bne_t", 7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 2, 4'b0001, 1'b1, 0, 1000);
        run_instr("bne_n", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 2, 4'b0001, 1'b0, 0, 1000);
        run_instr("bltu",  7'b1100011, 3'b110, 1'b0, 1'b0, 0, 0, 2, 4'b1000, 1'b1, 0, 1000);
        run_instr("beq",   7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 2, 4'b0001, 1'b1, 0, 1000);
        run_instr("bge",   7'b1100011, 3'b101, 1'b0, 1'b0, 0, 0, 2, 4'b1110, 1'b1, 0, 1000);
        run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 1, 3, 4, 4'b0000, 1'b0, 0, 1000);
        run_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 3, 4'b0000, 1'b0, 0, 1000);
        run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 2, 4'b0000, 1'b0, 0, 1000);
        run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0, 2, 4'b0000, 1'b0, 0, 1000);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 2, 4'b0000, 1'b1, 0, 1000);
        run_instr("jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 3, 4'b0000, 1'b1, 0, 1000);
        // Store parked in its memory-write wait, then reset lands mid-cycle
        run_instr("sw_ab", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 9, 3, 4'b0000, 1'b0, 0, 5);
        do_reset("sw_rst", 2);
        run_instr("add2",  7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 2, 4'b0010, 1'b0, 0, 1000);
        run_instr("ill",   7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 2, 4'b0000, 1'b0, TRAP ? 20 : 0, 1000);
        if (TRAP) do_reset("ill_rst", 1);
        run_instr("after", 7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0, 2, 4'b0100, 1'b0, 0, 1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
